// File: rtl/vpg_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vpg_timing_ctrl
//
// Video timing controller for a simple pattern generator. Walks a horizontal
// and a vertical counter through active / front porch / sync / back porch and
// produces registered raster timing plus the pattern select for the
// downstream pixel generator.
//
// Run control: IDLE -> RUN on enable. Dropping enable moves to DRAIN, which
// finishes the current frame and returns to IDLE after the last count.
// Raising enable again during DRAIN resumes RUN without disturbing the
// counters.
//
// Pattern select: pattern_load captures pattern_sel_in into a pending
// register. The pending value reaches image_color only at a frame boundary
// (counter wrap to (0,0) or IDLE->RUN), so the colour never changes inside a
// visible frame.
//
// Optional feature (compile-time macro VPG_AUTO_CYCLE_EN):
//   When defined, a frame counter counts completed frames and advances
//   image_color (mod 4) every FRAMES_PER_PATTERN frames. A pending load wins
//   over the automatic step and restarts the count. When undefined,
//   image_color changes only through pattern_load.
//
// Ports:
//   pixel_clk          in   sole clock, rising edge
//   reset              in   asynchronous, active-high
//   enable             in   run request
//   pattern_load       in   single-cycle strobe capturing pattern_sel_in
//   pattern_sel_in     in   [1:0] requested pattern
//   pixel_de           out  data enable
//   pixel_hs           out  horizontal sync, active-low
//   pixel_vs           out  vertical sync, active-low
//   pixel_x / pixel_y  out  [11:0] active-pixel coordinates (0 when blanked)
//   image_width        out  [11:0] constant H_ACTIVE
//   image_height       out  [11:0] constant V_ACTIVE
//   image_color        out  [1:0] pattern select
//   frame_start        out  one-cycle pulse coincident with pixel (0,0)
//   busy               out  high while in RUN or DRAIN
//
// All timing outputs are registered and show the counter state of the
// previous cycle (latency 1). image_color is delayed by the same stage so it
// switches together with frame_start.
// -----------------------------------------------------------------------------
module vpg_timing_ctrl #(
    parameter int H_ACTIVE           = 640,
    parameter int H_FP               = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BP               = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FP               = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BP               = 33,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pattern_load,
    input  logic [1:0]  pattern_sel_in,
    output logic        pixel_de,
    output logic        pixel_hs,
    output logic        pixel_vs,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic [11:0] image_width,
    output logic [11:0] image_height,
    output logic [1:0]  image_color,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;

    // Raster decode of the current counter state; registered below.
    logic h_last;
    logic frame_last;
    logic counting;
    logic de_d;
    logic hs_d;
    logic vs_d;

    assign h_last     = (h_cnt == H_LAST);
    assign frame_last = h_last && (v_cnt == V_LAST);
    assign counting   = (state == ST_RUN) || (state == ST_DRAIN);
    assign de_d       = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_d       = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    assign vs_d       = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

    assign image_width  = H_ACT_END;
    assign image_height = V_ACT_END;

    // -------------------------------------------------------------------------
    // Run-control FSM, raster counters and registered timing outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_de    <= 1'b0;
            pixel_hs    <= 1'b1;
            pixel_vs    <= 1'b1;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values; blocking assignments would
            // let the output decode see counters already advanced this edge.
            case (state)
                ST_IDLE: begin
                    // Counters rest at (0,0); outputs show the blank level.
                    pixel_de    <= 1'b0;
                    pixel_hs    <= 1'b1;
                    pixel_vs    <= 1'b1;
                    pixel_x     <= '0;
                    pixel_y     <= '0;
                    frame_start <= 1'b0;
                    if (enable) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    pixel_de    <= de_d;
                    pixel_hs    <= hs_d;
                    pixel_vs    <= vs_d;
                    pixel_x     <= de_d ? h_cnt : 12'd0;
                    pixel_y     <= de_d ? v_cnt : 12'd0;
                    frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);

                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
                    end else begin
                        h_cnt <= h_cnt + 12'd1;
                    end

                    // A frame that ends on the same cycle enable is seen low
                    // is already complete, so RUN may go straight to IDLE.
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (frame_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pattern select: pending register, frame-boundary update, optional
    // automatic cycling.
    // -------------------------------------------------------------------------
    logic       pending_vld;
    logic [1:0] pending_sel;
    logic [1:0] color_cur;
    logic       frame_done;
    logic       frame_boundary;
    logic       take_pending;
    logic [1:0] next_sel;

    assign frame_done     = counting && frame_last;
    assign frame_boundary = frame_done || ((state == ST_IDLE) && enable);
    // A load arriving on the boundary cycle itself is applied at that boundary.
    assign take_pending   = pattern_load || pending_vld;
    assign next_sel       = pattern_load ? pattern_sel_in : pending_sel;

`ifdef VPG_AUTO_CYCLE_EN
    localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

    logic [FC_W-1:0] frame_cnt;
`endif

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pending_vld <= 1'b0;
            pending_sel <= '0;
            color_cur   <= '0;
            image_color <= '0;
`ifdef VPG_AUTO_CYCLE_EN
            frame_cnt   <= '0;
`endif
        end else begin
            // Same one-cycle delay as the timing outputs, so the new colour
            // appears together with frame_start.
            image_color <= color_cur;

            if (frame_boundary && take_pending) begin
                color_cur   <= next_sel;
                pending_vld <= 1'b0;
`ifdef VPG_AUTO_CYCLE_EN
                frame_cnt   <= '0;
`endif
            end else begin
                if (pattern_load) begin
                    pending_sel <= pattern_sel_in;
                    pending_vld <= 1'b1;
                end
`ifdef VPG_AUTO_CYCLE_EN
                if (frame_done) begin
                    if (frame_cnt == FC_LAST) begin
                        color_cur <= color_cur + 2'd1;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vpg_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vpg_timing_ctrl
//
// Self-checking bench for vpg_timing_ctrl with a reduced raster
// (H 8/2/2/2 -> 14 clocks per line, V 4/1/1/1 -> 7 lines, 98 clocks/frame).
// Expected output words are derived from the raster formulas and pushed to a
// scoreboard queue as each cycle's stimulus is driven; they are popped and
// compared once the DUT has produced the output. A probe table holds
// hand-computed values at characteristic points of the first frame.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vpg_timing_ctrl;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HS  = 2;
    localparam int HB  = 2;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int FPP = 2;
    localparam int HT  = HA + HF + HS + HB;   // 14
    localparam int VT  = VA + VF + VS + VB;   // 7
    localparam int FT  = HT * VT;             // 98

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        pattern_load = 1'b0;
    logic [1:0]  pattern_sel_in = 2'd0;
    logic        pixel_de;
    logic        pixel_hs;
    logic        pixel_vs;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic [11:0] image_width;
    logic [11:0] image_height;
    logic [1:0]  image_color;
    logic        frame_start;
    logic        busy;

    vpg_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .enable        (enable),
        .pattern_load  (pattern_load),
        .pattern_sel_in(pattern_sel_in),
        .pixel_de      (pixel_de),
        .pixel_hs      (pixel_hs),
        .pixel_vs      (pixel_vs),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .image_width   (image_width),
        .image_height  (image_height),
        .image_color   (image_color),
        .frame_start   (frame_start),
        .busy          (busy)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        busy;
        logic [1:0]  color;
    } obs_t;   // 31 bits

    typedef struct {
        int   cyc;
        obs_t exp;
    } probe_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    obs_t   sb[$];
    probe_t probes[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic obs_t cur_obs();
        return {pixel_de, pixel_hs, pixel_vs, pixel_x, pixel_y, frame_start, busy, image_color};
    endfunction

    // Expected output for raster position p (clocks since frame start).
    function automatic obs_t pix(input int p, input logic b, input logic [1:0] c);
        obs_t o;
        int pp = p % FT;
        int h  = pp % HT;
        int v  = pp / HT;
        o.de    = (h < HA) && (v < VA);
        o.hs    = !((h >= HA + HF) && (h < HA + HF + HS));
        o.vs    = !((v >= VA + VF) && (v < VA + VF + VS));
        o.x     = o.de ? 12'(h) : 12'd0;
        o.y     = o.de ? 12'(v) : 12'd0;
        o.fs    = (pp == 0);
        o.busy  = b;
        o.color = c;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic b, input logic [1:0] c);
        obs_t o;
        o.de    = 1'b0;
        o.hs    = 1'b1;
        o.vs    = 1'b1;
        o.x     = 12'd0;
        o.y     = 12'd0;
        o.fs    = 1'b0;
        o.busy  = b;
        o.color = c;
        return o;
    endfunction

    function automatic obs_t mk(input logic de, input logic hs, input logic vs,
                                input int x, input int y, input logic fs);
        obs_t o;
        o.de    = de;
        o.hs    = hs;
        o.vs    = vs;
        o.x     = 12'(x);
        o.y     = 12'(y);
        o.fs    = fs;
        o.busy  = 1'b1;
        o.color = 2'd0;
        return o;
    endfunction

    // Push the expectation for the coming edge, clock once, pop and compare.
    task automatic step_cmp(input string name, input obs_t e);
        obs_t got_exp;
        sb.push_back(e);
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        cyc++;
        got_exp = sb.pop_front();
        check(name, {1'b0, cur_obs()}, {1'b0, got_exp});
    endtask

    // Hold reset for two clocks, release on a falling edge; the next rising
    // edge is cycle 1.
    task automatic do_reset(input logic en);
        reset        = 1'b1;
        pattern_load = 1'b0;
        enable       = en;
        repeat (2) @(negedge pixel_clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Expected image_color for the auto-cycling runs, indexed by frame.
    function automatic logic [1:0] auto_color(input int frame, input logic with_load);
        logic [1:0] tbl_plain [9];
        logic [1:0] tbl_load  [9];
        tbl_plain = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        tbl_load  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        return with_load ? tbl_load[frame] : tbl_plain[frame];
    endfunction

    initial begin
        int fs_first;
        int fs_second;
        obs_t e;
        logic [1:0] c;

        // Probe table: cycle after reset release -> hand-computed outputs.
        probes[0]  = '{2,   mk(1, 1, 1, 0, 0, 1)};   // pixel (0,0)
        probes[1]  = '{9,   mk(1, 1, 1, 7, 0, 0)};   // last active pixel, line 0
        probes[2]  = '{10,  mk(0, 1, 1, 0, 0, 0)};   // h=8 front porch
        probes[3]  = '{12,  mk(0, 0, 1, 0, 0, 0)};   // h=10 sync start
        probes[4]  = '{13,  mk(0, 0, 1, 0, 0, 0)};   // h=11 sync
        probes[5]  = '{14,  mk(0, 1, 1, 0, 0, 0)};   // h=12 back porch
        probes[6]  = '{16,  mk(1, 1, 1, 0, 1, 0)};   // (0,1)
        probes[7]  = '{19,  mk(1, 1, 1, 3, 1, 0)};   // (3,1)
        probes[8]  = '{51,  mk(1, 1, 1, 7, 3, 0)};   // (7,3) last visible pixel
        probes[9]  = '{58,  mk(0, 1, 1, 0, 0, 0)};   // (0,4) v front porch
        probes[10] = '{72,  mk(0, 1, 0, 0, 0, 0)};   // (0,5) v sync
        probes[11] = '{82,  mk(0, 0, 0, 0, 0, 0)};   // (10,5) both syncs
        probes[12] = '{86,  mk(0, 1, 1, 0, 0, 0)};   // (0,6) v back porch
        probes[13] = '{99,  mk(0, 1, 1, 0, 0, 0)};   // (13,6) last count
        probes[14] = '{100, mk(1, 1, 1, 0, 0, 1)};   // next frame (0,0)

        // ---- Reset state ---------------------------------------------------
        repeat (2) @(negedge pixel_clk);
        check("reset_state", {1'b0, cur_obs()}, {1'b0, idle_obs(1'b0, 2'd0)});
        check("image_width", 32'(image_width), 32'd8);
        check("image_height", 32'(image_height), 32'd4);

        // ---- Basic raster timing, frame period -----------------------------
        do_reset(1'b1);
        fs_first  = -1;
        fs_second = -1;
        for (int n = 1; n <= FT + 16; n++) begin
            e = (n == 1) ? idle_obs(1'b1, 2'd0) : pix(n - 2, 1'b1, 2'd0);
            step_cmp("raster", e);
            if (frame_start) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            foreach (probes[i])
                if (probes[i].cyc == n)
                    check("probe", {1'b0, cur_obs()}, {1'b0, probes[i].exp});
        end
        check("fs_first_cycle", 32'(fs_first), 32'd2);
        check("fs_period", 32'(fs_second - fs_first), 32'(FT));

        // ---- enable dropped at (3,1): frame drains, then idle --------------
        do_reset(1'b1);
        for (int n = 1; n <= FT + 8; n++) begin
            if (cyc == 18) enable = 1'b0;
            if (n == 1)       e = idle_obs(1'b1, 2'd0);
            else if (n < 99)  e = pix(n - 2, 1'b1, 2'd0);
            else if (n == 99) e = pix(FT - 1, 1'b0, 2'd0);
            else              e = idle_obs(1'b0, 2'd0);
            step_cmp("drain", e);
        end

        // ---- re-enable during DRAIN: no gap --------------------------------
        do_reset(1'b1);
        for (int n = 1; n <= FT + 16; n++) begin
            if (cyc == 18) enable = 1'b0;
            if (cyc == 30) enable = 1'b1;
            e = (n == 1) ? idle_obs(1'b1, 2'd0) : pix(n - 2, 1'b1, 2'd0);
            step_cmp("redrain", e);
        end

        // ---- pattern_load: mid-frame, overwrite, coincident with boundary --
        // Frame boundaries (wrap edges) fall on cycles 99, 197, 295, ...
        do_reset(1'b1);
        for (int n = 1; n <= 491; n++) begin
            pattern_load = (cyc == 30) || (cyc == 120) || (cyc == 125) || (cyc == 294);
            case (cyc)
                30:      pattern_sel_in = 2'd2;
                120:     pattern_sel_in = 2'd1;
                125:     pattern_sel_in = 2'd3;
                294:     pattern_sel_in = 2'd1;
                default: pattern_sel_in = 2'd0;
            endcase
            if (n < 100)      c = 2'd0;
            else if (n < 198) c = 2'd2;
            else if (n < 296) c = 2'd3;
            else              c = 2'd1;
            e = (n == 1) ? idle_obs(1'b1, 2'd0) : pix(n - 2, 1'b1, c);
            step_cmp("pattern", e);
        end
        pattern_load = 1'b0;

        // ---- asynchronous reset at (5,2), pending load discarded -----------
        do_reset(1'b1);
        for (int n = 1; n <= 35; n++) begin
            pattern_load   = (cyc == 10);
            pattern_sel_in = 2'd3;
            e = (n == 1) ? idle_obs(1'b1, 2'd0) : pix(n - 2, 1'b1, 2'd0);
            step_cmp("pre_reset", e);
        end
        pattern_load = 1'b0;
        check("at_5_2", {20'd0, pixel_x, pixel_y[7:0]}, {20'd0, 12'd5, 8'd2});
        reset = 1'b1;
        #2;
        check("async_reset", {1'b0, cur_obs()}, {1'b0, idle_obs(1'b0, 2'd0)});
        @(negedge pixel_clk);
        reset = 1'b0;
        cyc   = 0;
        for (int n = 1; n <= FT + 4; n++) begin
            e = (n == 1) ? idle_obs(1'b1, 2'd0) : pix(n - 2, 1'b1, 2'd0);
            step_cmp("restart", e);
        end

`ifdef VPG_AUTO_CYCLE_EN
        // ---- automatic cycling, plain and with a load in frame 3 -----------
        for (int run = 0; run < 2; run++) begin
            do_reset(1'b1);
            for (int n = 1; n <= 2 + 9 * FT - 1; n++) begin
                pattern_load   = (run == 1) && (cyc == 2 + 3 * FT + 30);
                pattern_sel_in = 2'd1;
                if (n == 1) e = idle_obs(1'b1, 2'd0);
                else        e = pix(n - 2, 1'b1, auto_color((n - 2) / FT, run == 1));
                step_cmp(run == 1 ? "auto_load" : "auto", e);
            end
            pattern_load = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/vpg_timing_ctrl.md
VPG_TIMING_CTRL -- requirements
Module: vpg_timing_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (units: lines).
  FRAMES_PER_PATTERN 60: frames per auto-cycle step.
REQ-002 SHALL have ports (name, direction, width, meaning):
  pixel_clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high.
  enable  in  1  run request.
  pattern_load  in  1  single-cycle strobe capturing pattern_sel_in.
  pattern_sel_in  in  2  requested pattern.
  pixel_de / pixel_hs / pixel_vs  out  1  data enable, h-sync, v-sync; syncs active-low.
  pixel_x / pixel_y  out  12  active-pixel coordinates.
  image_width / image_height  out  12  constant H_ACTIVE / V_ACTIVE.
  image_color  out  2  pattern select for the downstream generator.
  frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
  busy  out  1  high in RUN or DRAIN.

Function
REQ-003 SHALL hold h_cnt (0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) and v_cnt (0..V_TOTAL-1); order per line/frame: active, FP, sync, BP.
REQ-004 h_cnt SHALL increment every RUN/DRAIN cycle and wrap to 0 at H_TOTAL-1; v_cnt SHALL increment on each h wrap and wrap to 0 at V_TOTAL-1.
REQ-005 pixel_de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-006 pixel_hs SHALL be 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; pixel_vs SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-007 pixel_x/pixel_y SHALL equal h_cnt/v_cnt when pixel_de=1, else 0.
REQ-008 All outputs SHALL be registered and reflect counter state of the previous cycle (latency 1).
REQ-009 FSM states IDLE, RUN, DRAIN: IDLE->RUN when enable=1 (counters at 0,0); RUN->DRAIN when enable=0; DRAIN->RUN when enable=1 (no counter disturbance); DRAIN->IDLE at the last count (H_TOTAL-1, V_TOTAL-1).
REQ-010 In IDLE counters SHALL hold 0 and outputs SHALL be de=0, hs=1, vs=1, x=y=0, frame_start=0.
REQ-011 pattern_load SHALL write pattern_sel_in to a pending register; a later load before the boundary SHALL overwrite it.
REQ-012 A pending value SHALL be applied to image_color only at a frame boundary (counter wrap to 0,0, or IDLE->RUN), never mid-frame; load coincident with the boundary cycle SHALL be applied at that boundary.
REQ-013 image_color SHALL stay constant while pixel_de could be high within one frame.

Reset
REQ-014 reset SHALL force, asynchronously: state IDLE, counters 0, pixel_de=0, pixel_hs=1, pixel_vs=1, pixel_x=pixel_y=0, frame_start=0, busy=0, image_color=0, pending cleared, frame counter 0.
REQ-015 reset mid-frame SHALL abort the frame; after release the block SHALL re-enter RUN from (0,0) if enable=1.

Configuration
REQ-016 Macro VPG_AUTO_CYCLE_EN defined: a frame counter SHALL count completed frames; after FRAMES_PER_PATTERN it SHALL increment image_color (mod 4) at the boundary and clear; a pending load SHALL take priority and clear the counter.
REQ-017 Without VPG_AUTO_CYCLE_EN: no frame counter; image_color SHALL change only via pattern_load.

Verification (bench params H 8/2/2/2, V 4/1/1/1: H_TOTAL 14, V_TOTAL 7)
REQ-018 Reset, enable=1 -> de=1, x=0, y=0, frame_start=1 on 2nd edge after release; de high 8 cycles/line, 4 lines.
REQ-019 Sync timing -> hs=0 exactly at h_cnt 10-11; vs=0 for all of line 5; next frame_start 98 cycles after the first.
REQ-020 enable dropped at h=3, line 1 -> frame completes, busy falls after (13,6), outputs idle; re-enable in DRAIN -> no gap.
REQ-021 pattern_load sel=2 mid-frame -> image_color stays 0 until next frame_start, then 2; two loads (1 then 3) -> 3.
REQ-022 VPG_AUTO_CYCLE_EN, FRAMES_PER_PATTERN=2 -> image_color 0,0,1,1,2,2,3,3,0; load sel=1 during frame 3 -> 1 next frame, count restarts.
REQ-023 reset asserted at (5,2) -> outputs idle same cycle asynchronously; restart from (0,0).
